// File: rtl/bus_arbiter_2m.sv
// Two-master bus arbiter: one-hot grant and mux select for M0/M1, parked on M0, with a contested-hold limit.
// Optional switch counter enabled by defining ARB_SWITCH_CNT_EN.
//
// state | meaning
// S_M0  | M0 owns the bus (also the parking owner)
// S_M1  | M1 owns the bus
module bus_arbiter_2m #(
   parameter int MAX_HOLD = 16,
   parameter int HOLD_W   = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       m0_req,
   input  logic       m1_req,
   output logic       m0_grant,
   output logic       m1_grant,
   output logic [1:0] sel,
   output logic       grant_chg
`ifdef ARB_SWITCH_CNT_EN
   ,
   input  logic        switch_cnt_clr,
   output logic [15:0] switch_cnt
`endif
);

   // State encoding equals the mux select, so the grants come straight off the flops.
   typedef enum logic [1:0] {
      S_M0 = 2'b10,
      S_M1 = 2'b01
   } state_t;

   localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);
   localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

   state_t              state;
   state_t              state_next;
   logic [HOLD_W-1:0]   hold_cnt;
   logic [HOLD_W-1:0]   hold_next;
   logic                both;
   logic                limit_hit;
   logic                switching;

   always_comb begin
      both       = m0_req & m1_req;
      limit_hit  = (MAX_HOLD != 0) && both && (hold_cnt == HOLD_LAST);
      state_next = state;
      case (state)
         S_M0:    if ((m1_req && !m0_req) || limit_hit) state_next = S_M1;
         S_M1:    if (!m1_req || limit_hit) state_next = S_M0;
         default: state_next = S_M0;
      endcase
      switching = (state_next != state);
      hold_next = '0;
      // Only unbroken contention under the same owner accumulates.
      if ((MAX_HOLD != 0) && !switching && both) begin
         hold_next = (hold_cnt == HOLD_LAST) ? hold_cnt : hold_cnt + HOLD_ONE;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_M0;
         hold_cnt  <= '0;
         grant_chg <= 1'b0;
      end else begin
         state     <= state_next;
         hold_cnt  <= hold_next;
         grant_chg <= switching;
      end
   end

   assign m0_grant = state[1];
   assign m1_grant = state[0];
   assign sel      = {m0_grant, m1_grant};

`ifdef ARB_SWITCH_CNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         switch_cnt <= '0;
      end else if (switch_cnt_clr) begin
         switch_cnt <= '0;
      end else if (switching) begin
         switch_cnt <= switch_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// Bench for bus_arbiter_2m: three instances (MAX_HOLD 16, 4, 0) driven by directed vectors,
// expected responses queued at stimulus time and checked by an independent monitor.
module tb_bus_arbiter_2m;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        m0_r   [3];
   logic        m1_r   [3];
   logic        clr_r  [3];
   logic        g0     [3];
   logic        g1     [3];
   logic [1:0]  sel_o  [3];
   logic        chg_o  [3];
   logic [15:0] sw_o   [3];

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          id;
      logic [1:0]  sel;
      logic        chg;
      logic        chk_sw;
      logic [15:0] sw;
      string       nm;
   } item_t;

   item_t sb[$];

   always #5 clk = ~clk;

   bus_arbiter_2m #(.MAX_HOLD(16), .HOLD_W(8)) u16 (
      .clk(clk), .reset_n(reset_n), .m0_req(m0_r[0]), .m1_req(m1_r[0]),
      .m0_grant(g0[0]), .m1_grant(g1[0]), .sel(sel_o[0]), .grant_chg(chg_o[0])
`ifdef ARB_SWITCH_CNT_EN
      , .switch_cnt_clr(clr_r[0]), .switch_cnt(sw_o[0])
`endif
   );

   bus_arbiter_2m #(.MAX_HOLD(4), .HOLD_W(8)) u4 (
      .clk(clk), .reset_n(reset_n), .m0_req(m0_r[1]), .m1_req(m1_r[1]),
      .m0_grant(g0[1]), .m1_grant(g1[1]), .sel(sel_o[1]), .grant_chg(chg_o[1])
`ifdef ARB_SWITCH_CNT_EN
      , .switch_cnt_clr(clr_r[1]), .switch_cnt(sw_o[1])
`endif
   );

   bus_arbiter_2m #(.MAX_HOLD(0), .HOLD_W(8)) u0 (
      .clk(clk), .reset_n(reset_n), .m0_req(m0_r[2]), .m1_req(m1_r[2]),
      .m0_grant(g0[2]), .m1_grant(g1[2]), .sel(sel_o[2]), .grant_chg(chg_o[2])
`ifdef ARB_SWITCH_CNT_EN
      , .switch_cnt_clr(clr_r[2]), .switch_cnt(sw_o[2])
`endif
   );

   task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_item(input item_t it);
      cmp({it.nm, ".sel"}, {14'd0, sel_o[it.id]}, {14'd0, it.sel});
      cmp({it.nm, ".grants"}, {14'd0, g0[it.id], g1[it.id]}, {14'd0, it.sel});
      cmp({it.nm, ".chg"}, {15'd0, chg_o[it.id]}, {15'd0, it.chg});
`ifdef ARB_SWITCH_CNT_EN
      if (it.chk_sw) cmp({it.nm, ".switch_cnt"}, sw_o[it.id], it.sw);
`endif
   endtask

   // Monitor: the grants are sampled 1 time unit after each rising edge.
   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) check_item(sb.pop_front());
   end

   // Reset must act immediately, independent of the clock.
   always @(negedge reset_n) begin
      #1;
      while (sb.size() > 0) check_item(sb.pop_front());
   end

   task automatic push(input int id, input logic [1:0] esel, input bit echg, input string nm,
                       input bit csw, input logic [15:0] esw);
      item_t it;
      it.id = id; it.sel = esel; it.chg = echg; it.chk_sw = csw; it.sw = esw; it.nm = nm;
      sb.push_back(it);
   endtask

   task automatic step(input int id, input bit m0, input bit m1, input logic [1:0] esel,
                       input bit echg, input string nm, input bit clr = 1'b0,
                       input bit csw = 1'b0, input logic [15:0] esw = 16'h0);
      @(negedge clk);
      m0_r[id]  = m0;
      m1_r[id]  = m1;
      clr_r[id] = clr;
      push(id, esel, echg, nm, csw, esw);
      @(posedge clk);
   endtask

   task automatic pulse_reset(input int id, input string nm);
      @(negedge clk);
      #2;
      push(id, 2'b10, 1'b0, nm, 1'b1, 16'h0);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         m0_r[i] = 1'b0; m1_r[i] = 1'b0; clr_r[i] = 1'b0;
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // Parking on M0 with no requests
      for (int i = 0; i < 10; i++) step(0, 0, 0, 2'b10, 0, "park");

      // Simple handover and release back to M0
      step(0, 0, 1, 2'b01, 1, "ho_to_m1");
      step(0, 0, 1, 2'b01, 0, "ho_hold_m1");
      step(0, 0, 0, 2'b10, 1, "ho_back_m0");
      step(0, 0, 0, 2'b10, 0, "ho_park");

      // Owner wins ties below the hold limit
      step(0, 1, 0, 2'b10, 0, "tie_m0_only");
      for (int i = 0; i < 5; i++) step(0, 1, 1, 2'b10, 0, "tie_m0_keeps");
      step(0, 0, 1, 2'b01, 1, "tie_m0_drops");
      step(0, 1, 1, 2'b01, 0, "tie_m1_keeps");
      step(0, 1, 0, 2'b10, 1, "m1_release_to_m0");
      step(0, 0, 0, 2'b10, 0, "idle16");

      // Forced handover every 16 contested cycles
      for (int k = 1; k <= 32; k++)
         step(0, 1, 1, (k < 16) ? 2'b10 : (k < 32) ? 2'b01 : 2'b10, (k == 16 || k == 32),
              $sformatf("force16_%0d", k));
      step(0, 0, 0, 2'b10, 0, "idle16b");

      // Reset mid-transfer while M1 owns and still requests
      step(0, 0, 1, 2'b01, 1, "pre_rst_m1");
      pulse_reset(0, "rst_mid");
      step(0, 0, 1, 2'b01, 0, "post_rst_m1");
      step(0, 0, 0, 2'b10, 1, "post_rst_park");

      // MAX_HOLD=4 fairness: switch every 4 contested cycles
      for (int k = 1; k <= 9; k++)
         step(1, 1, 1, ((k / 4) % 2 == 0) ? 2'b10 : 2'b01, (k % 4 == 0),
              $sformatf("fair4_%0d", k));
      step(1, 0, 0, 2'b10, 0, "fair4_idle");

      // Contention gap restarts the hold count
      for (int k = 1; k <= 3; k++) step(1, 1, 1, 2'b10, 0, $sformatf("gap_pre_%0d", k));
      step(1, 1, 0, 2'b10, 0, "gap_break");
      for (int k = 1; k <= 3; k++) step(1, 1, 1, 2'b10, 0, $sformatf("gap_post_%0d", k));
      step(1, 1, 1, 2'b01, 1, "gap_switch");
      step(1, 0, 0, 2'b10, 1, "gap_release");

      // MAX_HOLD=0: no forced handover
      for (int k = 1; k <= 40; k++) step(2, 1, 1, 2'b10, 0, $sformatf("nolim_m0_%0d", k));
      step(2, 0, 1, 2'b01, 1, "nolim_to_m1");
      for (int k = 1; k <= 20; k++) step(2, 1, 1, 2'b01, 0, $sformatf("nolim_m1_%0d", k));
      step(2, 0, 0, 2'b10, 1, "nolim_back");

`ifdef ARB_SWITCH_CNT_EN
      pulse_reset(1, "rst_sw");
      step(1, 0, 1, 2'b01, 1, "sw_1", 0, 1, 16'd1);
      step(1, 0, 0, 2'b10, 1, "sw_2", 0, 1, 16'd2);
      step(1, 0, 1, 2'b01, 1, "sw_3", 0, 1, 16'd3);
      step(1, 0, 0, 2'b10, 1, "sw_clr_on_switch", 1, 1, 16'd0);
      for (int i = 0; i < 65534; i++) begin
         @(negedge clk);
         clr_r[1] = 1'b0;
         m1_r[1]  = (i % 2 == 0);
      end
      step(1, 0, 1, 2'b01, 1, "sw_ffff", 0, 1, 16'hFFFF);
      step(1, 0, 0, 2'b10, 1, "sw_wrap", 0, 1, 16'h0000);
`endif

      repeat (2) @(posedge clk);
      #2;
      cmp("sb_drained", 16'(sb.size()), 16'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bus_arbiter_2m.md
Name: bus_arbiter_2m

Overview:
Two-master bus arbiter that produces the one-hot grant driving the bus address/data/control muxes for master 0 (M0) and master 1 (M1). It sits directly upstream of the 32-bit bus muxes. Its sel output feeds the mux select directly: 2'b10 selects M0 and 2'b01 selects M1. Arbitration is request/hold based, with M0 as the default parking owner. An optional burst limit enforces fairness.

Parameters:
MAX_HOLD, 16, max consecutive contested cycles an owner keeps the bus before forced handover; 0 disables the limit
HOLD_W, 8, width of the internal hold counter; must satisfy 2^HOLD_W > MAX_HOLD

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
m0_req  input  1  M0 bus request, level
m1_req  input  1  M1 bus request, level
m0_grant  output  1  M0 owns bus, registered
m1_grant  output  1  M1 owns bus, registered
sel  output  2  {m0_grant, m1_grant}, mux select, combinational concat of registers
grant_chg  output  1  one-cycle pulse on the cycle the grant has just changed owner, registered

Behaviour:
- One clock (clk); reset is asynchronous, active-low (reset_n). All state updates on the rising clk edge.
- Reset (reset_n=0), immediately regardless of clk:
  - state=S_M0
  - m0_grant=1, m1_grant=0, sel=2'b10
  - hold_cnt=0, grant_chg=0
- Reset mid-transfer also forces S_M0.
- Grants are always exactly one-hot. sel is never 2'b00 or 2'b11.
- FSM states: S_M0 (M0 owns bus), S_M1 (M1 owns bus).
- S_M0 transitions:
  - m1_req=1 and m0_req=0 -> S_M1.
  - m1_req=1, m0_req=1, MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 -> S_M1 (forced).
  - Otherwise stay in S_M0, including the case where neither master requests (parking on M0).
- S_M1 transitions:
  - m1_req=0 -> S_M0, whether or not m0_req is set.
  - m0_req=1, m1_req=1, MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 -> S_M0 (forced).
  - Otherwise stay in S_M1.
- Latency: a request change becomes visible on the grants one clk edge later. No combinational path from req to grant.
- hold_cnt:
  - Cleared to 0 on any edge where the state changes.
  - Incremented on edges where the state holds and both m0_req and m1_req are 1.
  - Cleared to 0 on edges where the state holds and the requests are not both 1, so only contiguous contention counts.
  - Saturates at MAX_HOLD-1.
  - Held at 0 when MAX_HOLD==0.
- grant_chg = 1 on the cycle following a state change, 0 otherwise.
- Simultaneous requests from S_M0 after reset: M0 keeps the bus, because the current owner wins ties until the hold limit.
- Forced handover case: with MAX_HOLD=16 and both masters requesting continuously, ownership alternates every 16 cycles.
- Owner released while the other is idle:
  - In S_M1: drop to S_M0 (park).
  - In S_M0: stay.

Optional Feature:
ARB_SWITCH_CNT_EN
- Defined:
  - Adds output switch_cnt [15:0], a registered count of state changes.
  - Reset to 0 by reset_n.
  - Increments on each edge where the state changes and wraps from 16'hFFFF to 0.
  - Adds input switch_cnt_clr (1 bit), a synchronous clear that takes priority over increment.
- Undefined: neither port exists, and arbitration behaviour is identical.

Test Plan:
- Reset and parking: assert reset_n=0 mid-cycle with m1_req=1 -> m0_grant=1, m1_grant=0, sel=2'b10 immediately. Release reset with no requests for 10 cycles -> sel stays 2'b10, grant_chg=0.
- Simple handover: from S_M0 set m1_req=1, m0_req=0 -> sel=2'b01 and grant_chg=1 one edge later. Drop m1_req -> sel=2'b10 and grant_chg=1 one edge later.
- Owner wins tie: hold m0_req=1, then raise m1_req=1 for 5 cycles (MAX_HOLD=16) -> sel stays 2'b10. Drop m0_req -> sel=2'b01 next edge.
- Fairness: hold m0_req=m1_req=1 continuously, MAX_HOLD=4 -> sel sequence 10,10,10,10,01,01,01,01,10..., with grant_chg pulsing on each switch. With MAX_HOLD=0 -> sel stays 10 forever.
- Contention gap: with both masters requesting for 3 cycles (MAX_HOLD=4), deassert m1_req for 1 cycle, then reassert -> no switch until 4 further contiguous contested cycles.
- ARB_SWITCH_CNT_EN: run 3 handovers -> switch_cnt=3. Pulse switch_cnt_clr on the same edge as a switch -> switch_cnt=0. Preload the wrap scenario (65536 switches) -> switch_cnt wraps to 0.
